// File: rtl/amstrad_audio_post.sv
// Stereo post-processing for the 8-bit PSG mix: DC removal plus one-pole low-pass.
// Both channels are time-multiplexed through one datapath, six clocks per stereo sample.
module amstrad_audio_post #(
    parameter int DC_SHIFT = 12,
    parameter int LP_SHIFT = 2,
    parameter int DC_EN    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_in,
    input  logic [7:0]  audio_l,
    input  logic [7:0]  audio_r,
    input  logic        mute,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, L_DC, L_LP, R_DC, R_LP, DONE} state_t;

    state_t state, state_next;
    logic   take;

    logic [7:0] pend_l, pend_r, work_l, work_r;
    logic       pend_v;

    logic signed [23:0] dc_l, dc_r, lp_l, lp_r;
    logic signed [15:0] hp_reg;

    logic               sel_r;
    logic [7:0]         u_sel;
    logic signed [8:0]  u_c;
    logic signed [15:0] x_sel, hp_sat;
    logic signed [16:0] hp_wide;
    logic signed [23:0] dc_sel, lp_sel, dc_new, lp_new;
    logic signed [24:0] dc_diff, lp_diff, dc_step, lp_step;

    function automatic logic signed [23:0] sat24(input logic signed [24:0] v);
        if (v[24] != v[23]) return v[24] ? 24'sh800000 : 24'sh7fffff;
        return v[23:0];
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7fff;
        return v[15:0];
    endfunction

    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (pend_v) begin
                    state_next = L_DC;
                    take       = 1'b1;
                end
            end
            L_DC:    state_next = L_LP;
            L_LP:    state_next = R_DC;
            R_DC:    state_next = R_LP;
            R_LP:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A strobe coinciding with a take refills pending rather than counting as an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_l  <= 8'd0;
            pend_r  <= 8'd0;
            pend_v  <= 1'b0;
            work_l  <= 8'd0;
            work_r  <= 8'd0;
            overrun <= 1'b0;
        end else begin
            if (take) begin
                work_l <= pend_l;
                work_r <= pend_r;
            end
            if (ce_in) begin
                pend_l <= mute ? 8'd128 : audio_l;
                pend_r <= mute ? 8'd128 : audio_r;
                pend_v <= 1'b1;
                if (pend_v && !take) overrun <= 1'b1;
            end else if (take) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_comb begin
        sel_r  = (state == R_DC) || (state == R_LP);
        u_sel  = sel_r ? work_r : work_l;
        u_c    = $signed({1'b0, u_sel}) - 9'sd128;
        x_sel  = {u_c, 7'd0};
        dc_sel = sel_r ? dc_r : dc_l;
        lp_sel = sel_r ? lp_r : lp_l;

        if (DC_EN != 0) hp_wide = {x_sel[15], x_sel} - {dc_sel[23], dc_sel[23:8]};
        else            hp_wide = {x_sel[15], x_sel};
        hp_sat = sat16(hp_wide);

        dc_diff = {x_sel[15], x_sel, 8'd0} - {dc_sel[23], dc_sel};
        dc_step = dc_diff >>> DC_SHIFT;
        dc_new  = sat24({dc_sel[23], dc_sel} + dc_step);

        // The LP stage consumes the hp value registered during the preceding DC cycle.
        lp_diff = {hp_reg[15], hp_reg, 8'd0} - {lp_sel[23], lp_sel};
        lp_step = lp_diff >>> LP_SHIFT;
        lp_new  = sat24({lp_sel[23], lp_sel} + lp_step);
    end

    // lp stays within hp<<8, so lp[23:8] is already inside the 16-bit output range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_l   <= 24'sd0;
            dc_r   <= 24'sd0;
            lp_l   <= 24'sd0;
            lp_r   <= 24'sd0;
            hp_reg <= 16'sd0;
            out_l  <= 16'd0;
            out_r  <= 16'd0;
        end else begin
            case (state)
                L_DC: begin
                    dc_l   <= dc_new;
                    hp_reg <= hp_sat;
                end
                L_LP: begin
                    lp_l  <= lp_new;
                    out_l <= lp_new[23:8];
                end
                R_DC: begin
                    dc_r   <= dc_new;
                    hp_reg <= hp_sat;
                end
                R_LP: begin
                    lp_r  <= lp_new;
                    out_r <= lp_new[23:8];
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_amstrad_audio_post.sv
// Scoreboard bench for amstrad_audio_post: two configurations driven in parallel
// against an arithmetic reference model of the filter and of the capture/overrun rules.
module tb_amstrad_audio_post;

    localparam int DCS   = 12;
    localparam int LP0   = 2;
    localparam int DCEN0 = 1;
    localparam int LP1   = 0;
    localparam int DCEN1 = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_in = 1'b0;
    logic        mute = 1'b0;
    logic [7:0]  audio_l = 8'd128;
    logic [7:0]  audio_r = 8'd128;
    logic [15:0] out_l0, out_r0, out_l1, out_r1;
    logic        out_valid0, out_valid1, overrun0, overrun1;

    amstrad_audio_post #(.DC_SHIFT(DCS), .LP_SHIFT(LP0), .DC_EN(DCEN0)) dut0 (
        .clk(clk), .reset(reset), .ce_in(ce_in), .audio_l(audio_l), .audio_r(audio_r),
        .mute(mute), .out_l(out_l0), .out_r(out_r0), .out_valid(out_valid0), .overrun(overrun0)
    );

    amstrad_audio_post #(.DC_SHIFT(DCS), .LP_SHIFT(LP1), .DC_EN(DCEN1)) dut1 (
        .clk(clk), .reset(reset), .ce_in(ce_in), .audio_l(audio_l), .audio_r(audio_r),
        .mute(mute), .out_l(out_l1), .out_r(out_r1), .out_valid(out_valid1), .overrun(overrun1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int l0;
        int r0;
        int l1;
        int r1;
    } exp_t;

    typedef struct {
        int kind;
        int val;
    } side_t;

    exp_t  exp_q[$];
    side_t side_q[$];
    exp_t  mon_e;
    side_t mon_s;

    int n_cmp = 0;
    int n_fail = 0;

    longint mdc[2][2];
    longint mlp[2][2];
    int     next_idle = 0;
    bit     mp_v = 1'b0;
    bit     m_ovr = 1'b0;
    int     mp_l = 128;
    int     mp_r = 128;

    task automatic cmp(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // One filter step for channel ch of configuration cfg, from unsigned input u.
    function automatic int filt(input int cfg, input int ch, input int u);
        longint x, hp, r;
        int     lps;
        int     en;
        lps = (cfg == 0) ? LP0 : LP1;
        en  = (cfg == 0) ? DCEN0 : DCEN1;
        x   = longint'(u - 128) * 128;
        hp  = (en != 0) ? x - (mdc[cfg][ch] >>> 8) : x;
        hp  = clamp(hp, -32768, 32767);
        mdc[cfg][ch] = mdc[cfg][ch] + ((x * 256 - mdc[cfg][ch]) >>> DCS);
        mlp[cfg][ch] = mlp[cfg][ch] + ((hp * 256 - mlp[cfg][ch]) >>> lps);
        r = clamp(mlp[cfg][ch] >>> 8, -32768, 32767);
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int h = 0; h < 2; h++) begin
                mdc[c][h] = 0;
                mlp[c][h] = 0;
            end
        end
        mp_v  = 1'b0;
        m_ovr = 1'b0;
        exp_q.delete();
        side_q.delete();
    endtask

    task automatic push_side(input int kind, input int val);
        side_t s;
        s.kind = kind;
        s.val  = val;
        side_q.push_back(s);
    endtask

    // Drive one clock of stimulus; the model decides take/capture/overrun for this cycle.
    task automatic tick(input bit ce, input int l, input int r, input bit m);
        bit   tk;
        exp_t e;
        ce_in   = ce;
        audio_l = 8'(l);
        audio_r = 8'(r);
        mute    = m;
        tk = (cyc >= next_idle) && mp_v;
        if (tk) begin
            e.cyc = cyc + 5;
            e.l0  = filt(0, 0, mp_l);
            e.r0  = filt(0, 1, mp_r);
            e.l1  = filt(1, 0, mp_l);
            e.r1  = filt(1, 1, mp_r);
            exp_q.push_back(e);
            next_idle = cyc + 6;
        end
        if (ce) begin
            if (mp_v && !tk) m_ovr = 1'b1;
            mp_l = m ? 128 : l;
            mp_r = m ? 128 : r;
            mp_v = 1'b1;
        end else if (tk) begin
            mp_v = 1'b0;
        end
        @(posedge clk);
        #1;
        push_side(0, int'(m_ovr));
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() > 0 || mp_v) && k < 60) begin
            idle(1);
            k++;
        end
    endtask

    task automatic rand_strobe();
        tick(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3) == 0);
    endtask

    always @(negedge clk) begin
        while (side_q.size() > 0) begin
            mon_s = side_q.pop_front();
            if (mon_s.kind == 0) begin
                cmp("overrun_cfg0", int'(overrun0), mon_s.val);
                cmp("overrun_cfg1", int'(overrun1), mon_s.val);
            end else begin
                cmp("zero_out_l", int'(out_l0), 0);
                cmp("zero_out_r", int'(out_r0), 0);
                cmp("zero_out_l_cfg1", int'(out_l1), 0);
                cmp("zero_out_r_cfg1", int'(out_r1), 0);
                cmp("zero_valid", int'(out_valid0), 0);
                cmp("zero_overrun", int'(overrun0), 0);
            end
        end
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                cmp("valid_missing_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (out_valid0 || out_valid1) begin
                cmp("valid_pair", int'(out_valid1), int'(out_valid0));
                if (exp_q.size() == 0) begin
                    cmp("unexpected_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    cmp("valid_cycle", cyc, mon_e.cyc);
                    cmp("out_l_cfg0", int'($signed(out_l0)), mon_e.l0);
                    cmp("out_r_cfg0", int'($signed(out_r0)), mon_e.r0);
                    cmp("out_l_cfg1", int'($signed(out_l1)), mon_e.l1);
                    cmp("out_r_cfg1", int'($signed(out_r1)), mon_e.r1);
                end
            end
        end
    end

    initial begin
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        next_idle = cyc;
        push_side(1, 0);

        tick(1'b1, 128, 128, 1'b0);
        idle(8);
        tick(1'b1, 192, 64, 1'b0);
        idle(8);
        repeat (4) begin
            tick(1'b1, 192, 192, 1'b0);
            idle(5);
        end
        rand_strobe();
        idle(1);
        rand_strobe();
        idle(12);
        repeat (40) begin
            rand_strobe();
            idle($urandom_range(5, 9));
        end

        rand_strobe();
        rand_strobe();
        rand_strobe();
        idle(14);
        repeat (60) begin
            rand_strobe();
            idle($urandom_range(0, 7));
        end
        drain();

        // Abort a sample while the right channel is mid-way through its DC step.
        tick(1'b1, 200, 40, 1'b0);
        idle(3);
        reset = 1'b1;
        model_reset();
        push_side(1, 0);
        @(posedge clk);
        #1;
        push_side(1, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        next_idle = cyc;
        tick(1'b1, 128, 128, 1'b0);
        idle(10);
        drain();
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
